squash_game_sequencer: RTL and testbench
========================================

# squash_game_sequencer

Sequences the solo_squash game core. It holds the game in reset until the management SoC signals GPIO readiness, then stretches a clean reset pulse. It synchronizes and debounces the four active-low button pads, and runs the run/pause/new-game state machine. It sits between the Caravel pads/LA and the game datapath, replacing the direct pad-to-core wiring of the buttons.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops per pad input; minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronized input must differ from its stable value before the stable value flips; minimum 2.
- RESET_HOLD_CYCLES, 16: cycles design_reset stays high in HOLD; minimum 1.

Ports:
- wb_clk_i  in  1  sole clock.
- ext_reset_n  in  1  reset, synchronous, active-low.
- gpio_ready  in  1  LA bit from the CPU; 1 means pads are configured.
- pause_n, new_game_n, down_key_n, up_key_n  in  1 each  raw pad inputs, active-low, asynchronous.
- design_reset  out  1  active-high reset to the game core.
- game_pause  out  1  level; 1 while PAUSED.
- new_game_pulse  out  1  one-cycle strobe on an accepted new-game press.
- up_key, down_key  out  1 each  debounced, active-high movement.
- state_dbg  out  2  current FSM state code.

## Operation
- Reset (ext_reset_n=0 at a clock edge):
  - State is WAIT_GPIO and all synchronizer flops are 1.
  - Debounce stable values are 1 (released) and all counters are 0.
  - Outputs: design_reset=1, game_pause=0, new_game_pulse=0, up_key=0, down_key=0, state_dbg=0.
- gpio_ready passes through one register stage (gpio_q).
- Debounce, per button:
  - The button input goes through SYNC_STAGES flops.
  - If the synced value equals stable, the counter clears.
  - If it differs, the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the value still differs, stable takes the synced value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps.
- A press is a stable 1→0 transition. It is a one-cycle internal event.
- FSM states (package codes):
  - WAIT_GPIO=0: design_reset=1. Moves to HOLD when gpio_q=1.
  - HOLD=1: design_reset=1. The hold counter loads RESET_HOLD_CYCLES-1 on entry and decrements each cycle. Moves to RUN when the counter is 0.
  - RUN=2: design_reset=0.
    - new_game press → HOLD, with new_game_pulse=1 for that cycle.
    - Otherwise, pause press → PAUSED.
  - PAUSED=3: design_reset=0, game_pause=1.
    - new_game press → HOLD, with pulse.
    - Otherwise, pause press → RUN.
- gpio_q=0 in any state → WAIT_GPIO on the next edge. This takes priority over button events.
- Simultaneous pause and new_game presses: new_game wins and the pause press is discarded.
- Presses in WAIT_GPIO or HOLD are ignored. No pulse is generated.
- up_key = ~stable_up & stable_down and down_key = ~stable_down & stable_up, i.e. both held gives no movement. Both are forced to 0 unless the state is RUN.
- ext_reset_n=0 mid-operation returns to the reset values on that edge, including clearing any in-progress debounce count.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Pad low to stable low: SYNC_STAGES + DEBOUNCE_CYCLES edges. The FSM reacts on the following edge.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no stable change.
- gpio_ready rising to design_reset falling: 1 (gpio_q) + 1 (enter HOLD) + RESET_HOLD_CYCLES edges.
- design_reset rises on the same edge as new_game_pulse.
- new_game_pulse is exactly one cycle. game_pause changes on the state-transition edge.

## Structure
- Package squash_ctrl_pkg holds:
  - the state enum (2-bit) codes WAIT_GPIO, HOLD, RUN, PAUSED;
  - the default debounce and hold constants.
- Sub-module squash_debounce holds the synchronizer, counter and stable register, and outputs the stable value and a fall strobe. It is instantiated 4×. The top level contains gpio_q, the FSM, the hold counter and output registers.

## Test plan
Use SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and RESET_HOLD_CYCLES=8 unless noted.
- Reset release:
  - Stimulus: ext_reset_n low 3 cycles then high, with gpio_ready=0 for 20 cycles.
  - Required: design_reset=1 and state_dbg=0 throughout.
  - Stimulus: then raise gpio_ready.
  - Required: design_reset falls exactly 10 edges later and state_dbg=2.
- Debounce:
  - Stimulus: in RUN, pause_n low for 3 cycles then high.
  - Required: game_pause stays 0.
  - Stimulus: pause_n held low.
  - Required: game_pause=1 at edge 7 after the falling edge.
- Pause toggle:
  - Stimulus: a second debounced pause press.
  - Required: state_dbg returns to 2 and game_pause=0.
  - Stimulus: up_key_n held low while PAUSED.
  - Required: up_key=0.
- Simultaneous press:
  - Stimulus: pause_n and new_game_n fall on the same cycle in RUN.
  - Required: a single-cycle new_game_pulse, state HOLD, design_reset=1 for 8 cycles, then RUN with game_pause=0.
- Both keys held:
  - Stimulus: up_key_n and down_key_n both held low in RUN.
  - Required: up_key=0 and down_key=0.
  - Stimulus: release down.
  - Required: up_key=1 after 6 edges.
- gpio_ready drop and mid-run reset:
  - Stimulus: drop gpio_ready while PAUSED.
  - Required: WAIT_GPIO within 2 edges, design_reset=1 and game_pause=0.
  - Stimulus: ext_reset_n low during a partial debounce count.
  - Required: all outputs return to reset values and the count restarts from 0.

Source files
------------

// File: rtl/squash_ctrl_pkg.sv
// Shared types and defaults for the solo_squash game sequencer.
package squash_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_GPIO = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    PAUSED    = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES       = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 50000;
  localparam int unsigned DEFAULT_RESET_HOLD_CYCLES = 16;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/squash_debounce.sv
// Pad synchronizer plus debounce filter for one active-low button.
// stable_next is the value the stable register takes at the coming edge; fall is a registered 1->0 strobe.
module squash_debounce
  import squash_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_n,
  output logic stable_next,
  output logic fall
);

  localparam int unsigned     CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   synced;

  assign synced      = sync_q[SYNC_STAGES-1];
  assign stable_next = stable_d;

  // Count consecutive disagreeing cycles; flip only after a full run of them.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      fall     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pad_n};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      fall     <= stable_q & ~stable_d;
    end
  end

endmodule

// File: rtl/squash_game_sequencer.sv
// Reset sequencing, button conditioning and run/pause/new-game control for the solo_squash core.
module squash_game_sequencer
  import squash_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
  input  logic       wb_clk_i,
  input  logic       ext_reset_n,
  input  logic       gpio_ready,
  input  logic       pause_n,
  input  logic       new_game_n,
  input  logic       down_key_n,
  input  logic       up_key_n,
  output logic       design_reset,
  output logic       game_pause,
  output logic       new_game_pulse,
  output logic       up_key,
  output logic       down_key,
  output logic [1:0] state_dbg
);

  localparam int unsigned       HOLD_W    = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD_CYCLES - 1);

  state_e            state_q;
  state_e            state_d;
  logic              gpio_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  logic design_reset_d;
  logic game_pause_d;
  logic new_game_pulse_d;
  logic up_key_d;
  logic down_key_d;

  logic pause_fall;
  logic new_game_fall;
  logic up_level;
  logic down_level;
  logic unused_pause_level;
  logic unused_new_game_level;
  logic unused_up_fall;
  logic unused_down_fall;

  squash_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(wb_clk_i), .rst_n(ext_reset_n), .pad_n(pause_n),
    .stable_next(unused_pause_level), .fall(pause_fall)
  );

  squash_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_new_game (
    .clk(wb_clk_i), .rst_n(ext_reset_n), .pad_n(new_game_n),
    .stable_next(unused_new_game_level), .fall(new_game_fall)
  );

  squash_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(wb_clk_i), .rst_n(ext_reset_n), .pad_n(up_key_n),
    .stable_next(up_level), .fall(unused_up_fall)
  );

  squash_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(wb_clk_i), .rst_n(ext_reset_n), .pad_n(down_key_n),
    .stable_next(down_level), .fall(unused_down_fall)
  );

  // Losing gpio readiness overrides everything; new_game beats pause on the same cycle.
  always_comb begin
    state_d          = state_q;
    hold_d           = hold_q;
    new_game_pulse_d = 1'b0;

    if (!gpio_q) begin
      state_d = WAIT_GPIO;
    end else begin
      case (state_q)
        WAIT_GPIO: state_d = HOLD;
        HOLD:      if (hold_q == '0) state_d = RUN;
        RUN: begin
          if (new_game_fall) begin
            state_d          = HOLD;
            new_game_pulse_d = 1'b1;
          end else if (pause_fall) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (new_game_fall) begin
            state_d          = HOLD;
            new_game_pulse_d = 1'b1;
          end else if (pause_fall) begin
            state_d = RUN;
          end
        end
        default: state_d = WAIT_GPIO;
      endcase
    end

    if ((state_d == HOLD) && (state_q != HOLD)) begin
      hold_d = HOLD_LOAD;
    end else if ((state_q == HOLD) && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    // Outputs follow the next state so they change on the transition edge.
    design_reset_d = (state_d == WAIT_GPIO) || (state_d == HOLD);
    game_pause_d   = (state_d == PAUSED);
    up_key_d       = (state_d == RUN) && !up_level && down_level;
    down_key_d     = (state_d == RUN) && !down_level && up_level;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!ext_reset_n) begin
      state_q        <= WAIT_GPIO;
      gpio_q         <= 1'b0;
      hold_q         <= '0;
      design_reset   <= 1'b1;
      game_pause     <= 1'b0;
      new_game_pulse <= 1'b0;
      up_key         <= 1'b0;
      down_key       <= 1'b0;
    end else begin
      state_q        <= state_d;
      gpio_q         <= gpio_ready;
      hold_q         <= hold_d;
      design_reset   <= design_reset_d;
      game_pause     <= game_pause_d;
      new_game_pulse <= new_game_pulse_d;
      up_key         <= up_key_d;
      down_key       <= down_key_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_squash_game_sequencer.sv
// Scoreboard bench for squash_game_sequencer: each step queues inputs with the outputs expected after the next edge.
module tb_squash_game_sequencer;

  // Output vector {design_reset, game_pause, new_game_pulse, up_key, down_key, state_dbg}
  localparam logic [6:0] O_WAIT   = 7'b1000000;
  localparam logic [6:0] O_HOLD   = 7'b1000001;
  localparam logic [6:0] O_RUN    = 7'b0000010;
  localparam logic [6:0] O_PAUSED = 7'b0100011;
  localparam logic [6:0] O_PULSE  = 7'b1010001;
  localparam logic [6:0] O_RUN_UP = 7'b0001010;
  localparam logic [6:0] O_RUN_DN = 7'b0000110;

  // Input vector {ext_reset_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n}
  localparam logic [5:0] I_RST_NOGPIO  = 6'b001111;
  localparam logic [5:0] I_IDLE_NOGPIO = 6'b101111;
  localparam logic [5:0] I_IDLE        = 6'b111111;
  localparam logic [5:0] I_PAUSE       = 6'b110111;
  localparam logic [5:0] I_BOTH_PN     = 6'b110011;
  localparam logic [5:0] I_UP          = 6'b111101;
  localparam logic [5:0] I_DN          = 6'b111110;
  localparam logic [5:0] I_UPDN        = 6'b111100;
  localparam logic [5:0] I_RST_PAUSE   = 6'b010111;

  typedef struct {
    logic [5:0] in;
    logic [6:0] exp;
    string      tag;
  } step_t;

  step_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       gpio_ready = 1'b0;
  logic       pause_n    = 1'b1;
  logic       new_game_n = 1'b1;
  logic       down_key_n = 1'b1;
  logic       up_key_n   = 1'b1;
  logic       design_reset;
  logic       game_pause;
  logic       new_game_pulse;
  logic       up_key;
  logic       down_key;
  logic [1:0] state_dbg;
  logic [6:0] outs;

  always #5 clk = ~clk;

  squash_game_sequencer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD_CYCLES(8)
  ) dut (
    .wb_clk_i(clk),
    .ext_reset_n(rst_n),
    .gpio_ready(gpio_ready),
    .pause_n(pause_n),
    .new_game_n(new_game_n),
    .down_key_n(down_key_n),
    .up_key_n(up_key_n),
    .design_reset(design_reset),
    .game_pause(game_pause),
    .new_game_pulse(new_game_pulse),
    .up_key(up_key),
    .down_key(down_key),
    .state_dbg(state_dbg)
  );

  assign outs = {design_reset, game_pause, new_game_pulse, up_key, down_key, state_dbg};

  task automatic push(input logic [5:0] in, input logic [6:0] e, input int n, input string tag);
    step_t s;
    s.in  = in;
    s.exp = e;
    s.tag = tag;
    for (int i = 0; i < n; i++) sb_q.push_back(s);
  endtask

  task automatic test_reset();
    step_t s;
    push(I_RST_NOGPIO,  O_WAIT, 3,  "reset");
    push(I_IDLE_NOGPIO, O_WAIT, 20, "wait_gpio");
    push(I_IDLE,        O_WAIT, 1,  "gpio_sync");
    push(I_IDLE,        O_HOLD, 8,  "hold");
    push(I_IDLE,        O_RUN,  3,  "run_entry");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      {rst_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n} = s.in;
      @(posedge clk); #1;
      n_cmp++;
      if (outs !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b at %0t", s.tag, outs, s.exp, $time);
      end
    end
  endtask

  task automatic test_debounce();
    step_t s;
    push(I_PAUSE, O_RUN,    3, "bounce_low");
    push(I_IDLE,  O_RUN,    6, "bounce_reject");
    push(I_PAUSE, O_RUN,    6, "debounce_wait");
    push(I_PAUSE, O_PAUSED, 3, "pause_edge7");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      {rst_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n} = s.in;
      @(posedge clk); #1;
      n_cmp++;
      if (outs !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b at %0t", s.tag, outs, s.exp, $time);
      end
    end
  endtask

  task automatic test_pause_toggle();
    step_t s;
    push(I_UP,    O_PAUSED, 10, "up_paused");
    push(I_IDLE,  O_PAUSED, 8,  "up_release");
    push(I_PAUSE, O_PAUSED, 6,  "unpause_wait");
    push(I_PAUSE, O_RUN,    3,  "unpause");
    push(I_IDLE,  O_RUN,    8,  "unpause_release");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      {rst_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n} = s.in;
      @(posedge clk); #1;
      n_cmp++;
      if (outs !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b at %0t", s.tag, outs, s.exp, $time);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s;
    push(I_BOTH_PN, O_RUN,   6, "simul_wait");
    push(I_BOTH_PN, O_PULSE, 1, "simul_pulse");
    push(I_BOTH_PN, O_HOLD,  7, "simul_hold");
    push(I_BOTH_PN, O_RUN,   3, "simul_run");
    push(I_IDLE,    O_RUN,   8, "simul_release");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      {rst_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n} = s.in;
      @(posedge clk); #1;
      n_cmp++;
      if (outs !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b at %0t", s.tag, outs, s.exp, $time);
      end
    end
  endtask

  task automatic test_keys();
    step_t s;
    push(I_UPDN, O_RUN,    10, "both_held");
    push(I_UP,   O_RUN,    5,  "down_release_wait");
    push(I_UP,   O_RUN_UP, 3,  "up_move");
    push(I_DN,   O_RUN_UP, 5,  "swap_wait");
    push(I_DN,   O_RUN_DN, 3,  "down_move");
    push(I_IDLE, O_RUN_DN, 5,  "key_release_wait");
    push(I_IDLE, O_RUN,    3,  "key_idle");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      {rst_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n} = s.in;
      @(posedge clk); #1;
      n_cmp++;
      if (outs !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b at %0t", s.tag, outs, s.exp, $time);
      end
    end
  endtask

  task automatic test_gpio_drop();
    step_t s;
    push(I_PAUSE,       O_RUN,    6, "drop_pause_wait");
    push(I_PAUSE,       O_PAUSED, 1, "drop_paused");
    push(I_IDLE_NOGPIO, O_PAUSED, 1, "drop_sync");
    push(I_IDLE_NOGPIO, O_WAIT,   7, "drop_wait");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      {rst_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n} = s.in;
      @(posedge clk); #1;
      n_cmp++;
      if (outs !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b at %0t", s.tag, outs, s.exp, $time);
      end
    end
  endtask

  task automatic test_mid_reset();
    step_t s;
    push(I_IDLE,      O_WAIT,   1, "regain_sync");
    push(I_IDLE,      O_HOLD,   8, "regain_hold");
    push(I_IDLE,      O_RUN,    2, "regain_run");
    push(I_PAUSE,     O_RUN,    4, "partial_count");
    push(I_RST_PAUSE, O_WAIT,   1, "mid_reset");
    push(I_PAUSE,     O_WAIT,   1, "post_reset_sync");
    push(I_PAUSE,     O_HOLD,   8, "post_reset_hold");
    push(I_PAUSE,     O_RUN,    4, "held_press_ignored");
    push(I_IDLE,      O_RUN,    8, "post_reset_release");
    push(I_PAUSE,     O_RUN,    6, "restart_wait");
    push(I_PAUSE,     O_PAUSED, 2, "restart_pause");
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      {rst_n, gpio_ready, pause_n, new_game_n, up_key_n, down_key_n} = s.in;
      @(posedge clk); #1;
      n_cmp++;
      if (outs !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b at %0t", s.tag, outs, s.exp, $time);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_pause_toggle();
    test_simultaneous();
    test_keys();
    test_gpio_drop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
